// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step sequencer for the single-cycle RISC-V core.
//
// Gates the core's architectural-state update through cpu_en. Execution stops
// on an illegal instruction, a PC breakpoint, a committed-cycle watchdog or a
// host HALT command. While halted, the host can single-step the core or dump
// the 32-entry register file through the RF debug read port.
//
// Ports:
//   clk, rstn            core clock (rising edge), async active-low reset
//   cmd_valid/cmd_op     host command strobe and opcode
//                        (0 RUN, 1 HALT, 2 STEP, 3 DUMP, 4 CLRCNT, 5-7 no-op)
//   cmd_ready            command accepted when cmd_valid & cmd_ready
//   pc, illegal          current core PC and decoder illegal flag
//   bp_en, bp_addr       PC breakpoint enable and address
//   max_cycles           watchdog limit on committed cycles, 0 disables
//   cpu_en               core may commit the current instruction
//   reg_sel, reg_data    RF debug read select / combinational read data
//   dump_valid/idx/data  one register-file dump beat
//   dump_done            one-cycle pulse after dump entry 31
//   halted, halt_reason  halted status and cause
//                        (0 NONE, 1 CMD, 2 BP, 3 WDOG, 4 ILLEGAL, 5 STEP)
//   cycle_cnt            saturating count of committed cycles
module cpu_run_ctrl #(
  parameter bit RUN_ON_RESET = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [31:0]      pc,
  input  logic             illegal,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             cpu_en,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             dump_done,
  output logic             halted,
  output logic [2:0]       halt_reason,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2,
    ST_DUMP   = 2'd3
  } state_t;

  localparam state_t ST_RESET = RUN_ON_RESET ? ST_RUN : ST_HALTED;

  localparam logic [2:0] OP_RUN    = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_DUMP   = 3'd3;
  localparam logic [2:0] OP_CLRCNT = 3'd4;

  localparam logic [2:0] RSN_NONE    = 3'd0;
  localparam logic [2:0] RSN_CMD     = 3'd1;
  localparam logic [2:0] RSN_BP      = 3'd2;
  localparam logic [2:0] RSN_WDOG    = 3'd3;
  localparam logic [2:0] RSN_ILLEGAL = 3'd4;
  localparam logic [2:0] RSN_STEP    = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_r;
  logic             skip_bp_r;
  logic [2:0]       halt_reason_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [4:0]       reg_sel_r;
  logic             dump_valid_r;
  logic [4:0]       dump_idx_r;
  logic [31:0]      dump_data_r;
  logic             dump_done_r;
  logic             dump_last_r;

  logic             stop_ill_s;
  logic             stop_bp_s;
  logic             stop_wd_s;
  logic             stop_any_s;
  logic [2:0]       stop_code_s;
  logic             cpu_en_s;
  logic             cmd_ready_s;
  logic             cmd_fire_s;

  // Stop-condition detection and priority encoding (ILLEGAL > BP > WDOG).
  always_comb begin
    stop_ill_s  = illegal;
    stop_bp_s   = bp_en && (pc == bp_addr) && !skip_bp_r;
    // Compared before the increment so exactly max_cycles instructions commit.
    stop_wd_s   = (max_cycles != CNT_ZERO) && (cycle_cnt_r >= max_cycles);
    stop_any_s  = stop_ill_s || stop_bp_s || stop_wd_s;
    stop_code_s = RSN_NONE;
    if (stop_ill_s) begin
      stop_code_s = RSN_ILLEGAL;
    end else if (stop_bp_s) begin
      stop_code_s = RSN_BP;
    end else if (stop_wd_s) begin
      stop_code_s = RSN_WDOG;
    end else begin
      stop_code_s = RSN_NONE;
    end
  end

  // Commit gate and command handshake, decoded from the current state.
  always_comb begin
    cpu_en_s    = 1'b0;
    cmd_ready_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        // The offending instruction of a stop condition is never committed.
        cpu_en_s    = !stop_any_s;
        cmd_ready_s = 1'b1;
      end
      ST_HALTED: begin
        cpu_en_s    = 1'b0;
        cmd_ready_s = 1'b1;
      end
      ST_STEP: begin
        cpu_en_s    = !illegal;
        cmd_ready_s = 1'b0;
      end
      ST_DUMP: begin
        cpu_en_s    = 1'b0;
        cmd_ready_s = 1'b0;
      end
      default: begin
        cpu_en_s    = 1'b0;
        cmd_ready_s = 1'b0;
      end
    endcase
    cmd_fire_s = cmd_valid && cmd_ready_s;
  end

  // Sequencer state, committed-cycle counter and register-file dump datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_RESET;
      skip_bp_r     <= 1'b0;
      halt_reason_r <= RSN_NONE;
      cycle_cnt_r   <= CNT_ZERO;
      reg_sel_r     <= 5'd0;
      dump_valid_r  <= 1'b0;
      dump_idx_r    <= 5'd0;
      dump_data_r   <= 32'd0;
      dump_done_r   <= 1'b0;
      dump_last_r   <= 1'b0;
    end else begin
      dump_valid_r <= 1'b0;
      dump_done_r  <= 1'b0;

      // A clear issued in the same cycle as a commit takes precedence.
      if (cmd_fire_s && (cmd_op == OP_CLRCNT)) begin
        cycle_cnt_r <= CNT_ZERO;
      end else if (cpu_en_s && (cycle_cnt_r != CNT_MAX)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end

      // The breakpoint bypass only covers the first committed instruction.
      if (cpu_en_s) begin
        skip_bp_r <= 1'b0;
      end

      case (state_r)
        ST_RUN: begin
          if (stop_any_s) begin
            state_r       <= ST_HALTED;
            halt_reason_r <= stop_code_s;
          end else if (cmd_fire_s && (cmd_op == OP_HALT)) begin
            state_r       <= ST_HALTED;
            halt_reason_r <= RSN_CMD;
          end
        end
        ST_HALTED: begin
          if (cmd_fire_s) begin
            case (cmd_op)
              OP_RUN: begin
                state_r       <= ST_RUN;
                halt_reason_r <= RSN_NONE;
                // Resuming on the breakpoint PC must not re-trigger it.
                skip_bp_r     <= (pc == bp_addr);
              end
              OP_STEP: begin
                state_r <= ST_STEP;
              end
              OP_DUMP: begin
                state_r     <= ST_DUMP;
                reg_sel_r   <= 5'd0;
                dump_last_r <= 1'b0;
              end
              default: begin
              end
            endcase
          end
        end
        ST_STEP: begin
          state_r       <= ST_HALTED;
          halt_reason_r <= illegal ? RSN_ILLEGAL : RSN_STEP;
        end
        ST_DUMP: begin
          if (dump_last_r) begin
            dump_done_r <= 1'b1;
            dump_last_r <= 1'b0;
            reg_sel_r   <= 5'd0;
            state_r     <= ST_HALTED;
          end else begin
            dump_valid_r <= 1'b1;
            dump_idx_r   <= reg_sel_r;
            // x0 is hardwired to zero regardless of what the read port returns.
            dump_data_r  <= (reg_sel_r == 5'd0) ? 32'd0 : reg_data;
            if (reg_sel_r == 5'd31) begin
              dump_last_r <= 1'b1;
            end else begin
              reg_sel_r <= reg_sel_r + 5'd1;
            end
          end
        end
        default: begin
          state_r <= ST_HALTED;
        end
      endcase
    end
  end

  assign cpu_en      = cpu_en_s;
  assign cmd_ready   = cmd_ready_s;
  assign halted      = (state_r == ST_HALTED);
  assign halt_reason = halt_reason_r;
  assign cycle_cnt   = cycle_cnt_r;
  assign reg_sel     = reg_sel_r;
  assign dump_valid  = dump_valid_r;
  assign dump_idx    = dump_idx_r;
  assign dump_data   = dump_data_r;
  assign dump_done   = dump_done_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl (RUN_ON_RESET=1, CNT_W=32).
// A behavioural model of the run/halt/step/dump rules runs alongside the DUT
// and is compared every cycle; a vector table covers stop-condition priority
// and directed sequences cover breakpoint resume, watchdog, step, dump and
// reset-during-dump.
module tb_cpu_run_ctrl;
  localparam int CNT_W = 32;
  localparam int MD_RUN  = 0;
  localparam int MD_HALT = 1;
  localparam int MD_STEP = 2;
  localparam int MD_DUMP = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic             cmd_ready;
  logic [31:0]      pc;
  logic             illegal;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [CNT_W-1:0] max_cycles;
  logic             cpu_en;
  logic [4:0]       reg_sel;
  logic [31:0]      reg_data;
  logic             dump_valid;
  logic [4:0]       dump_idx;
  logic [31:0]      dump_data;
  logic             dump_done;
  logic             halted;
  logic [2:0]       halt_reason;
  logic [CNT_W-1:0] cycle_cnt;

  logic [31:0] rf [32];
  assign reg_data = rf[reg_sel];

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RUN_ON_RESET(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .pc(pc), .illegal(illegal), .bp_en(bp_en),
    .bp_addr(bp_addr), .max_cycles(max_cycles), .cpu_en(cpu_en),
    .reg_sel(reg_sel), .reg_data(reg_data), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done),
    .halted(halted), .halt_reason(halt_reason), .cycle_cnt(cycle_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // DUT-observed pulse counters, sampled mid-cycle
  int en_pulses   = 0;
  int done_pulses = 0;
  always @(negedge clk) begin
    if (cpu_en) en_pulses++;
    if (dump_done) done_pulses++;
  end

  // behavioural model state
  int          m_mode;
  bit          m_skip;
  int          m_pos;
  logic [2:0]  m_reason;
  logic [31:0] m_cnt;
  bit          m_dv;
  bit          m_done;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  bit          m_last_commit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_bp_hit();
    return bp_en && (pc == bp_addr) && !m_skip;
  endfunction

  function automatic bit m_wd_hit();
    return (max_cycles != 0) && (m_cnt >= max_cycles);
  endfunction

  function automatic bit m_commit();
    if (m_mode == MD_RUN) return !(illegal || m_bp_hit() || m_wd_hit());
    if (m_mode == MD_STEP) return !illegal;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_mode = MD_RUN; m_skip = 1'b0; m_pos = 0; m_reason = 3'd0; m_cnt = 32'd0;
    m_dv = 1'b0; m_done = 1'b0; m_idx = 5'd0; m_data = 32'd0;
  endtask

  task automatic m_step();
    bit c, fire, ill, bp, wd;
    c    = m_commit();
    fire = cmd_valid && (m_mode == MD_RUN || m_mode == MD_HALT);
    ill  = illegal;
    bp   = m_bp_hit();
    wd   = m_wd_hit();
    m_last_commit = c;
    m_dv = 1'b0;
    m_done = 1'b0;
    if (fire && cmd_op == 3'd4) m_cnt = 32'd0;
    else if (c && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (c) m_skip = 1'b0;
    case (m_mode)
      MD_RUN: begin
        if (ill)      begin m_mode = MD_HALT; m_reason = 3'd4; end
        else if (bp)  begin m_mode = MD_HALT; m_reason = 3'd2; end
        else if (wd)  begin m_mode = MD_HALT; m_reason = 3'd3; end
        else if (fire && cmd_op == 3'd1) begin m_mode = MD_HALT; m_reason = 3'd1; end
      end
      MD_HALT: begin
        if (fire) begin
          if (cmd_op == 3'd0) begin
            m_mode = MD_RUN; m_reason = 3'd0; m_skip = (pc == bp_addr);
          end else if (cmd_op == 3'd2) begin
            m_mode = MD_STEP;
          end else if (cmd_op == 3'd3) begin
            m_mode = MD_DUMP; m_pos = 0;
          end
        end
      end
      MD_STEP: begin
        m_mode = MD_HALT;
        m_reason = ill ? 3'd4 : 3'd5;
      end
      default: begin
        if (m_pos < 32) begin
          m_dv = 1'b1; m_idx = m_pos[4:0];
          m_data = (m_pos == 0) ? 32'd0 : rf[m_pos];
          m_pos++;
        end else begin
          m_done = 1'b1; m_mode = MD_HALT;
        end
      end
    endcase
  endtask

  task automatic compare_model();
    check("cpu_en", cpu_en, m_commit());
    check("cmd_ready", cmd_ready, (m_mode == MD_RUN || m_mode == MD_HALT));
    check("halted", halted, (m_mode == MD_HALT));
    check("halt_reason", halt_reason, m_reason);
    check("cycle_cnt", cycle_cnt, m_cnt);
    check("dump_valid", dump_valid, m_dv);
    check("dump_done", dump_done, m_done);
    if (m_dv) begin
      check("dump_idx", dump_idx, m_idx);
      check("dump_data", dump_data, m_data);
    end
    if (m_mode == MD_DUMP && m_pos <= 31) check("reg_sel", reg_sel, m_pos[4:0]);
  endtask

  // one clock: compare mid-cycle, advance the model on the edge
  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    if (rstn) m_step();
    else m_reset();
    #1;
  endtask

  task automatic set_idle();
    cmd_valid = 1'b0; cmd_op = 3'd0; illegal = 1'b0; bp_en = 1'b0;
    max_cycles = '0; pc = 32'h100; bp_addr = 32'h200;
  endtask

  task automatic send_cmd(input logic [2:0] op);
    cmd_valid = 1'b1; cmd_op = op;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_reason"}, halt_reason, 3'd0);
    check({tag, "_cnt"}, cycle_cnt, 32'd0);
    check({tag, "_reg_sel"}, reg_sel, 5'd0);
    check({tag, "_dump_valid"}, dump_valid, 1'b0);
    check({tag, "_dump_done"}, dump_done, 1'b0);
    check({tag, "_dump_idx"}, dump_idx, 5'd0);
    check({tag, "_dump_data"}, dump_data, 32'd0);
  endtask

  typedef struct {
    bit          vld;
    logic [2:0]  op;
    bit          ill;
    bit          bpe;
    bit          hit;
    logic [31:0] maxc;
    bit          e_en;
    bit          e_halt;
    logic [2:0]  e_rsn;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int en0, beats, done_at, dn0;
    logic [31:0] d0, d7, d31;
    bit idx_ok;

    for (int i = 0; i < 32; i++) rf[i] = i * 32'h1111_1111;

    // stop-condition table; cycle_cnt is 1 when each vector is applied
    //               vld  op    ill  bpe  hit  maxc   en   halt rsn   cnt
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd2});
    tbl.push_back('{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3'd1, 32'd2});
    tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 3'd4, 32'd1});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 3'd2, 32'd1});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 3'd0, 32'd2});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1, 3'd3, 32'd1});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1, 1'b0, 3'd0, 32'd2});
    tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1, 3'd4, 32'd1});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1, 3'd2, 32'd1});
    tbl.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 3'd4, 32'd1});
    tbl.push_back('{1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 3'd2, 32'd1});
    tbl.push_back('{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1, 3'd3, 32'd1});
    tbl.push_back('{1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0});
    tbl.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd2});
    tbl.push_back('{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd2});
    tbl.push_back('{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1, 1'b1, 3'd1, 32'd2});

    // reset, with the breakpoint scenario's inputs already in place
    rstn = 1'b0;
    m_last_commit = 1'b0;
    set_idle();
    bp_en = 1'b1; bp_addr = 32'h310; pc = 32'h0;
    m_reset();
    #12;
    check_reset_values("reset");
    check("reset_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    rstn = 1'b1;

    // breakpoint at 0x310 with PC advancing by 4 per commit
    for (int i = 0; i < 400 && m_mode != MD_HALT; i++) begin
      tick();
      if (m_last_commit) pc = pc + 32'd4;
    end
    check("bp_halted", halted, 1'b1);
    check("bp_reason", halt_reason, 3'd2);
    check("bp_cnt", cycle_cnt, 32'd196);

    // resume from the breakpoint PC: it commits once without re-triggering
    send_cmd(3'd0);
    tick();
    if (m_last_commit) pc = pc + 32'd4;
    check("resume_cnt", cycle_cnt, 32'd197);
    check("resume_running", halted, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_last_commit) pc = pc + 32'd4;
    end
    check("resume_no_retrigger", halted, 1'b0);
    send_cmd(3'd1);
    check("halt_cmd_reason", halt_reason, 3'd1);

    // watchdog: exactly max_cycles commits, then CLRCNT
    set_idle();
    send_cmd(3'd4);
    check("clr_before_wd", cycle_cnt, 32'd0);
    max_cycles = 32'd1000;
    send_cmd(3'd0);
    for (int i = 0; i < 1100 && m_mode != MD_HALT; i++) tick();
    check("wd_halted", halted, 1'b1);
    check("wd_reason", halt_reason, 3'd3);
    check("wd_cnt", cycle_cnt, 32'd1000);
    send_cmd(3'd4);
    check("clrcnt", cycle_cnt, 32'd0);
    max_cycles = '0;

    // single steps: one commit each, reason STEP, then an illegal step
    en0 = en_pulses;
    for (int k = 0; k < 3; k++) begin
      send_cmd(3'd2);
      check("step_ready_low", cmd_ready, 1'b0);
      tick();
      check("step_reason", halt_reason, 3'd5);
      check("step_halted", halted, 1'b1);
    end
    check("step_pulses", en_pulses - en0, 32'd3);
    en0 = en_pulses;
    send_cmd(3'd2);
    illegal = 1'b1;
    tick();
    illegal = 1'b0;
    check("step_ill_no_commit", en_pulses - en0, 32'd0);
    check("step_ill_reason", halt_reason, 3'd4);

    // full register-file dump
    send_cmd(3'd3);
    beats = 0; done_at = 0; idx_ok = 1'b1;
    d0 = 32'hDEAD_BEEF; d7 = 32'd0; d31 = 32'd0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      tick();
      if (dump_valid) begin
        check("dump_seq_idx", dump_idx, beats[4:0]);
        if (dump_idx == 5'd0) d0 = dump_data;
        if (dump_idx == 5'd7) d7 = dump_data;
        if (dump_idx == 5'd31) d31 = dump_data;
        beats++;
      end
      if (dump_done) done_at = k;
    end
    check("dump_beats", beats, 32'd32);
    check("dump_data0", d0, 32'd0);
    check("dump_data7", d7, 32'h7777_7777);
    check("dump_data31", d31, rf[31]);
    check("dump_done_cycle", done_at, 32'd33);
    check("dump_reason_kept", halt_reason, 3'd4);
    check("dump_back_halted", halted, 1'b1);

    // table: stop-condition priority and command effects in RUN
    foreach (tbl[i]) begin
      set_idle();
      if (m_mode == MD_RUN) send_cmd(3'd1);
      send_cmd(3'd4);
      send_cmd(3'd0);
      tick();
      cmd_valid = tbl[i].vld; cmd_op = tbl[i].op; illegal = tbl[i].ill;
      bp_en = tbl[i].bpe; pc = tbl[i].hit ? 32'h200 : 32'h100; max_cycles = tbl[i].maxc;
      en0 = en_pulses;
      tick();
      check($sformatf("tbl%0d_cpu_en", i), en_pulses - en0, tbl[i].e_en);
      check($sformatf("tbl%0d_halted", i), halted, tbl[i].e_halt);
      check($sformatf("tbl%0d_reason", i), halt_reason, tbl[i].e_rsn);
      check($sformatf("tbl%0d_cnt", i), cycle_cnt, tbl[i].e_cnt);
    end
    set_idle();

    // reset asserted at dump beat 10 aborts without dump_done
    if (m_mode == MD_RUN) send_cmd(3'd1);
    send_cmd(3'd3);
    for (int k = 0; k < 20 && !(m_dv && m_idx == 5'd10); k++) tick();
    check("abort_at_beat10", dump_idx, 5'd10);
    dn0 = done_pulses;
    rstn = 1'b0;
    #1;
    m_reset();
    check_reset_values("abort");
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    check("abort_no_done", done_pulses - dn0, 32'd0);

    // randomized traffic against the model
    set_idle();
    bp_addr = 32'h40;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 9) == 0);
      cmd_op    = 3'($urandom_range(0, 7));
      illegal   = ($urandom_range(0, 39) == 0);
      bp_en     = 1'($urandom_range(0, 1));
      pc        = ($urandom_range(0, 3) == 0) ? 32'h40 : 32'($urandom_range(0, 31) * 4);
      if ($urandom_range(0, 49) == 0)
        max_cycles = ($urandom_range(0, 2) == 0) ? 32'd0 : m_cnt + 32'($urandom_range(0, 30));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
